// File: rtl/iot_riscv_pkg.sv
// -----------------------------------------------------------------------------
// iot_riscv_pkg
// Shared types and constants for the RISC-V M-extension divide controller.
//   div_op_e    : op_i encodings (DIV, DIVU, REM, REMU)
//   div_state_e : divide controller FSM encodings
//   DIV_ZERO_QUOT / DIV_OVF_QUOT : architecturally defined quotients for
//                 divide-by-zero and signed overflow
// -----------------------------------------------------------------------------
package iot_riscv_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'd0,
    DIV_OP_DIVU = 2'd1,
    DIV_OP_REM  = 2'd2,
    DIV_OP_REMU = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ITER  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } div_state_e;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_QUOT  = 32'h8000_0000;

  // DIV and REM treat operands as two's complement.
  function automatic logic is_signed_op(div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  // REM/REMU return the remainder, DIV/DIVU the quotient.
  function automatic logic is_rem_op(div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

  function automatic logic [31:0] abs32(logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/iot_riscv_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// iot_riscv_div_ctrl_if
// Execute-stage <-> divider handshake bundle.
//   req_i/op_i/opa_i/opb_i/flush_i : driven by the requester (master)
//   res_o/valid_o/stall_o/busy_o   : driven by the divider (slave)
// -----------------------------------------------------------------------------
interface iot_riscv_div_ctrl_if;
  import iot_riscv_pkg::*;

  logic        req_i;
  div_op_e     op_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        flush_i;
  logic [31:0] res_o;
  logic        valid_o;
  logic        stall_o;
  logic        busy_o;

  modport master (
    output req_i, op_i, opa_i, opb_i, flush_i,
    input  res_o, valid_o, stall_o, busy_o
  );

  modport slave (
    input  req_i, op_i, opa_i, opb_i, flush_i,
    output res_o, valid_o, stall_o, busy_o
  );
endinterface

// File: rtl/iot_riscv_div_step.sv
// -----------------------------------------------------------------------------
// iot_riscv_div_step
// One restoring-division iteration, purely combinational.
//   rem_i : partial remainder (always < div_i)
//   quo_i : quotient register; dividend bits shift out of its MSB while
//           quotient bits shift in at its LSB
//   div_i : divisor magnitude
//   rem_o / quo_o : values after this iteration
// -----------------------------------------------------------------------------
module iot_riscv_div_step (
  input  logic [31:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] div_i,
  output logic [31:0] rem_o,
  output logic [31:0] quo_o
);

  logic [32:0] shifted;
  logic [32:0] trial;

  // shifted < 2*div_i, so the 33-bit difference lies in (-2^32, 2^32) and
  // its MSB is a reliable sign bit.
  assign shifted = {rem_i, quo_i[31]};
  assign trial   = shifted - {1'b0, div_i};

  assign rem_o = trial[32] ? shifted[31:0] : trial[31:0];
  assign quo_o = {quo_i[30:0], ~trial[32]};

endmodule

// File: rtl/iot_riscv_div_ctrl.sv
// -----------------------------------------------------------------------------
// iot_riscv_div_ctrl
// Multi-cycle RV32M divide/remainder unit with divide-by-zero and signed
// overflow fast paths and an optional single-entry last-result cache.
//   cache_en_p    : 1 enables the last-result cache
//   main_clk_i    : clock, all state on rising edge
//   main_rst_an_i : asynchronous active-low reset
//   bus (slave)   : req_i/op_i/opa_i/opb_i/flush_i in,
//                   res_o/valid_o/stall_o/busy_o out
// Full operations take 34 cycles from request to valid_o (32 iterations plus
// sign fixup); fast paths and cache hits complete in 1.
// -----------------------------------------------------------------------------
module iot_riscv_div_ctrl
  import iot_riscv_pkg::*;
#(
  parameter bit cache_en_p = 1'b1
) (
  input  logic                  main_clk_i,
  input  logic                  main_rst_an_i,
  iot_riscv_div_ctrl_if.slave   bus
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic [31:0] opa_q, opb_q;
  div_op_e     op_q;
  logic        neg_quo_q, neg_rem_q;

  logic        c_valid_q, c_sgn_q;
  logic [31:0] c_opa_q, c_opb_q, c_quo_q, c_rem_q;

  logic        req_signed, opb_zero, ovf, cache_hit, fast, start;
  logic [31:0] step_rem, step_quo;

  assign req_signed = is_signed_op(bus.op_i);
  assign opb_zero   = (bus.opb_i == 32'd0);
  assign ovf        = req_signed && (bus.opa_i == DIV_OVF_QUOT) && (bus.opb_i == 32'hFFFF_FFFF);
  assign cache_hit  = cache_en_p && c_valid_q && (bus.opa_i == c_opa_q) &&
                      (bus.opb_i == c_opb_q) && (req_signed == c_sgn_q);
  assign fast       = opb_zero || ovf || cache_hit;
  assign start      = (state_q == ST_IDLE) && bus.req_i && !bus.flush_i;

  iot_riscv_div_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  // NOTE: next state defaults to the current state before the case so no
  // path leaves state_d unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = fast ? ST_DONE : ST_ITER;
      ST_ITER:  if (cnt_q == 5'd0) state_d = ST_FIXUP;
      ST_FIXUP: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
    endcase
    if (bus.flush_i) state_d = ST_IDLE;
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      cnt_q     <= 5'd0;
      quo_q     <= 32'd0;
      rem_q     <= 32'd0;
      dvs_q     <= 32'd0;
      opa_q     <= 32'd0;
      opb_q     <= 32'd0;
      op_q      <= DIV_OP_DIV;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      // NOTE: the cache is a handful of flops, not a RAM, so it is reset
      // outright; clearing c_valid_q alone would already block stale hits.
      c_valid_q <= 1'b0;
      c_sgn_q   <= 1'b0;
      c_opa_q   <= 32'd0;
      c_opb_q   <= 32'd0;
      c_quo_q   <= 32'd0;
      c_rem_q   <= 32'd0;
    end else if (!bus.flush_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_i) begin
            op_q  <= bus.op_i;
            opa_q <= bus.opa_i;
            opb_q <= bus.opb_i;
            if (opb_zero) begin
              quo_q <= DIV_ZERO_QUOT;
              rem_q <= bus.opa_i;
            end else if (ovf) begin
              quo_q <= DIV_OVF_QUOT;
              rem_q <= 32'd0;
            end else if (cache_hit) begin
              quo_q <= c_quo_q;
              rem_q <= c_rem_q;
            end else begin
              // Iterate on magnitudes; signs are restored in FIXUP.
              quo_q     <= req_signed ? abs32(bus.opa_i) : bus.opa_i;
              dvs_q     <= req_signed ? abs32(bus.opb_i) : bus.opb_i;
              rem_q     <= 32'd0;
              neg_quo_q <= req_signed && (bus.opa_i[31] ^ bus.opb_i[31]);
              neg_rem_q <= req_signed && bus.opa_i[31];
              cnt_q     <= 5'd31;
            end
          end
        end
        ST_ITER: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
        end
        ST_FIXUP: begin
          if (neg_quo_q) quo_q <= ~quo_q + 32'd1;
          if (neg_rem_q) rem_q <= ~rem_q + 32'd1;
        end
        ST_DONE: begin
          c_valid_q <= 1'b1;
          c_sgn_q   <= is_signed_op(op_q);
          c_opa_q   <= opa_q;
          c_opb_q   <= opb_q;
          c_quo_q   <= quo_q;
          c_rem_q   <= rem_q;
        end
      endcase
    end
  end

  // A flush in DONE kills the result strobe in the same cycle.
  assign bus.valid_o = (state_q == ST_DONE) && !bus.flush_i;
  assign bus.res_o   = !bus.valid_o ? 32'd0 : (is_rem_op(op_q) ? rem_q : quo_q);
  assign bus.stall_o = bus.req_i && !bus.valid_o;
  assign bus.busy_o  = (state_q != ST_IDLE);

endmodule

// File: doc/iot_riscv_div_ctrl.md
IOT_RISCV_DIV_CTRL -- requirements
Module: iot_riscv_div_ctrl

Interface
REQ-001 SHALL have parameter cache_en_p, default 1; 1 enables the last-result cache (REQ-019).
REQ-002 SHALL have port main_clk_i, input, 1 bit: single clock; all state on rising edge.
REQ-003 SHALL have port main_rst_an_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port req_i, input, 1 bit: divide request from execute stage.
REQ-005 SHALL have port op_i, input, 2 bits: 0 DIV, 1 DIVU, 2 REM, 3 REMU.
REQ-006 SHALL have port opa_i, input, 32 bits: dividend; SHALL have port opb_i, input, 32 bits: divisor.
REQ-007 SHALL have port flush_i, input, 1 bit: pipeline kill; aborts any operation.
REQ-008 SHALL have port res_o, output, 32 bits: result, valid only while valid_o=1.
REQ-009 SHALL have port valid_o, output, 1 bit: single-cycle result strobe.
REQ-010 SHALL have port stall_o, output, 1 bit: execute-stage stall request.
REQ-011 SHALL have port busy_o, output, 1 bit: state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, ITER, FIXUP, DONE; cycle 0 = cycle req_i is sampled high in IDLE.
REQ-013 In IDLE with req_i=1 and no fast path: latch |opa|, |opb| (signed ops only), result signs, op; counter=31; go ITER.
REQ-014 ITER SHALL perform one restoring step per cycle (33-bit trial subtract, shift quotient bit in); counter decrements; leave ITER after counter=0, i.e. cycles 1..32.
REQ-015 FIXUP (cycle 33) SHALL negate quotient if signs(opa)^signs(opb) and negate remainder if sign(opa), signed ops only; go DONE.
REQ-016 DONE (cycle 34) SHALL drive valid_o=1 and res_o = quotient (DIV/DIVU) or remainder (REM/REMU); next state IDLE unconditionally.
REQ-017 Fast path, divisor 0: DONE at cycle 1; quotient 0xFFFFFFFF, remainder = opa_i (all ops).
REQ-018 Fast path, signed overflow (opa=0x80000000, opb=0xFFFFFFFF, DIV/REM): DONE at cycle 1; quotient 0x80000000, remainder 0.
REQ-019 Cache hit (cache_en_p=1, cache valid, opa/opb/signedness equal to last completed op): DONE at cycle 1 returning cached quotient or remainder per op_i.
REQ-020 Cache SHALL update (quotient, remainder, operands, signedness, valid) on every DONE, including fast paths.
REQ-021 stall_o SHALL equal req_i & ~valid_o (combinational); asserted in cycle 0 of every request.
REQ-022 Requester SHALL hold req_i, op_i, opa_i, opb_i stable until valid_o; block samples operands only in IDLE.
REQ-023 After DONE the block SHALL spend one IDLE cycle before sampling a new request; req_i held high in that cycle starts a new operation.
REQ-024 flush_i=1 in any state SHALL force IDLE next cycle, suppress valid_o in that cycle, leave cache unchanged; flush_i with req_i in IDLE SHALL not start an operation.
REQ-025 res_o SHALL be 0 when valid_o=0.

Reset
REQ-026 On main_rst_an_i low: state IDLE, counter 0, quotient/remainder/operand registers 0, cache valid 0.
REQ-027 Reset values of outputs: res_o 0, valid_o 0, busy_o 0; stall_o follows req_i.
REQ-028 Reset mid-operation SHALL abort with no valid_o after release; first request after release takes full latency.

Structure
REQ-029 Package iot_riscv_pkg SHALL hold div_op_e (op encodings), div_state_e (FSM encodings), and constants DIV_ZERO_QUOT (0xFFFFFFFF), DIV_OVF_QUOT (0x80000000).
REQ-030 One combinational sub-module iot_riscv_div_step SHALL implement a single restoring iteration (inputs: partial remainder, quotient, divisor; outputs: next remainder, next quotient).

Verification
REQ-031 DIV 100/7 -> valid_o at cycle 34, res_o=14; stall_o high cycles 0..33, low at 34.
REQ-032 REM -7/2 (0xFFFFFFF9, 2) -> cycle 34 res_o=0xFFFFFFFF (-1); REMU same operands -> 0x00000001.
REQ-033 DIVU 5/0 -> cycle 1 res_o=0xFFFFFFFF; REM 5/0 -> res_o=5.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> cycle 1 res_o=0x80000000; REM same -> res_o=0.
REQ-035 DIV 100/7 completes, then REM 100/7 -> cycle 1 res_o=2 (cache hit); with cache_en_p=0 -> cycle 34 res_o=2.
REQ-036 DIVU 1000/3, flush_i at cycle 10 -> IDLE cycle 11, no valid_o; new DIVU 9/3 -> cycle 34 res_o=3.
